// File: rtl/stage2_pool_collector.sv
// stage2_pool_collector
//   Collects the 12x12 pooled feature map from the stage-2 max-pool stream into
//   a two-bank (ping-pong) frame buffer. When a bank is complete, the block replays
//   that frame to the flatten/FC stage over valid/ready. Capture continues in the
//   other bank while the replay runs.
//
//   Optional build macro: ST2_COLLECT_TRANSPOSE_EN
//     defined   : replay is column-major (addr = r*OUT_X + c, with r as the inner index)
//     undefined : replay is raster order (addr = k)
//
//   Ports
//     clk, reset      clock; synchronous active-high reset
//     i_in_valid      one pooled point this cycle (no backpressure to the source)
//     i_in_fmap       pooled point, raster order
//     o_ot_valid      replay point valid, held until accepted
//     o_ot_fmap       replay point
//     o_ot_last       final point of the frame
//     i_ot_ready      downstream accept
//     o_frame_done    one-cycle pulse when a bank fills
//     o_overflow      sticky: an input point was dropped
module stage2_pool_collector #(
    parameter int DW    = 19,
    parameter int OUT_X = 12,
    parameter int OUT_Y = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_fmap,
    output logic          o_ot_valid,
    output logic [DW-1:0] o_ot_fmap,
    output logic          o_ot_last,
    input  logic          i_ot_ready,
    output logic          o_frame_done,
    output logic          o_overflow
);
    localparam int FRAME = OUT_X * OUT_Y;
    localparam int AW    = $clog2(FRAME);
    localparam logic [AW-1:0] LAST_A = AW'(FRAME - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_e;

    logic [DW-1:0] mem_q [2][FRAME];

    logic          wr_bank_q, rd_bank_q;
    logic [AW-1:0] wr_addr_q, rd_addr_q, rd_addr_nxt;
    logic [1:0]    full_q, full_d;
    rd_state_e     state_q;
    logic          ot_valid_q, ot_last_q;
    logic [DW-1:0] ot_fmap_q;
    logic          done_q, ovf_q;
    logic          rel, wr_ok, wr_end, rd_is_last;

    // Last handshake of a replay frees its bank this very cycle.
    assign rel    = (state_q == SEND) && ot_valid_q && i_ot_ready && ot_last_q;
    // A write into a full bank is still taken when that bank is being freed now.
    assign wr_ok  = i_in_valid && (!full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q)));
    assign wr_end = wr_ok && (wr_addr_q == LAST_A);

    always_comb begin
        full_d = full_q;
        if (rel)    full_d[rd_bank_q] = 1'b0;
        if (wr_end) full_d[wr_bank_q] = 1'b1;
    end

    // Frame storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_bank_q][wr_addr_q] <= i_in_fmap;
    end

    // Write side
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            full_q <= full_d;
            done_q <= wr_end;
            if (i_in_valid && !wr_ok) ovf_q <= 1'b1;
            if (wr_ok) begin
                if (wr_end) begin
                    wr_addr_q <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_addr_q <= wr_addr_q + AW'(1);
                end
            end
        end
    end

`ifdef ST2_COLLECT_TRANSPOSE_EN
    // Column-major walk: row counter is the inner index, so the address steps
    // by OUT_X down a column and jumps back to the top of the next column.
    localparam int RW = $clog2(OUT_Y);
    localparam int CW = $clog2(OUT_X);
    logic [RW-1:0] rd_row_q;
    logic [CW-1:0] rd_col_q;
    logic          row_end;

    assign row_end     = (rd_row_q == RW'(OUT_Y - 1));
    assign rd_is_last  = row_end && (rd_col_q == CW'(OUT_X - 1));
    assign rd_addr_nxt = row_end ? (AW'(rd_col_q) + AW'(1)) : (rd_addr_q + AW'(OUT_X));

    always_ff @(posedge clk) begin
        if (reset || rel) begin
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else if ((state_q == SEND) && i_ot_ready) begin
            if (row_end) begin
                rd_row_q <= '0;
                rd_col_q <= rd_col_q + CW'(1);
            end else begin
                rd_row_q <= rd_row_q + RW'(1);
            end
        end
    end
`else
    assign rd_is_last  = (rd_addr_q == LAST_A);
    assign rd_addr_nxt = rd_addr_q + AW'(1);
`endif

    // Read FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            ot_valid_q <= 1'b0;
            ot_last_q  <= 1'b0;
            ot_fmap_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (full_q[rd_bank_q]) state_q <= FETCH;
                FETCH: begin
                    ot_fmap_q  <= mem_q[rd_bank_q][rd_addr_q];
                    ot_valid_q <= 1'b1;
                    ot_last_q  <= rd_is_last;
                    state_q    <= SEND;
                end
                SEND: if (i_ot_ready) begin
                    ot_valid_q <= 1'b0;
                    ot_last_q  <= 1'b0;
                    if (ot_last_q) begin
                        rd_bank_q <= ~rd_bank_q;
                        rd_addr_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        rd_addr_q <= rd_addr_nxt;
                        state_q   <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ot_valid   = ot_valid_q;
    assign o_ot_fmap    = ot_fmap_q;
    assign o_ot_last    = ot_last_q;
    assign o_frame_done = done_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_stage2_pool_collector.sv
module tb_stage2_pool_collector;
    localparam int DW    = 19;
    localparam int OUT_X = 12;
    localparam int OUT_Y = 12;
    localparam int FRAME = OUT_X * OUT_Y;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_in_valid = 1'b0;
    logic [DW-1:0] i_in_fmap = '0;
    logic          i_ot_ready = 1'b0;
    logic          o_ot_valid, o_ot_last, o_frame_done, o_overflow;
    logic [DW-1:0] o_ot_fmap;

    stage2_pool_collector #(.DW(DW), .OUT_X(OUT_X), .OUT_Y(OUT_Y)) dut (
        .clk(clk), .reset(reset),
        .i_in_valid(i_in_valid), .i_in_fmap(i_in_fmap),
        .o_ot_valid(o_ot_valid), .o_ot_fmap(o_ot_fmap), .o_ot_last(o_ot_last),
        .i_ot_ready(i_ot_ready),
        .o_frame_done(o_frame_done), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    exp_t          expq[$];     // points the DUT still owes downstream, in order
    logic [DW-1:0] cur[$];      // points of the frame being captured (raster order)
    int            held;        // complete frames not yet fully replayed (0..2)
    int            n_out, n_chk, n_fail;
    bit            exp_ov, done_pend, prev_stall;
    logic [DW-1:0] prev_fmap;
    logic          prev_last;
    int            rdy_mode;    // 0: ready=1, 1: ready=0, 2: random with stalls, 3: manual
    int            stall_cnt;

    // Position in the captured raster frame of the k-th replayed point.
    function automatic int rd_index(input int k);
`ifdef ST2_COLLECT_TRANSPOSE_EN
        return (k % OUT_Y) * OUT_X + (k / OUT_Y);
`else
        return k;
`endif
    endfunction

    // Reference model + scoreboard, evaluated each cycle before the rising edge.
    always @(negedge clk) begin
        exp_t e;
        bit   hs, rel;
        if (reset === 1'b1) begin
            expq.delete(); cur.delete();
            held = 0; exp_ov = 0; done_pend = 0; prev_stall = 0; n_out = 0;
        end else begin
            n_chk++;
            if (o_frame_done !== done_pend) begin
                n_fail++; $display("FAIL frame_done: got %b want %b", o_frame_done, done_pend);
            end
            n_chk++;
            if (o_overflow !== exp_ov) begin
                n_fail++; $display("FAIL overflow: got %b want %b", o_overflow, exp_ov);
            end
            n_chk++;
            if (o_ot_last === 1'b1 && o_ot_valid !== 1'b1) begin
                n_fail++; $display("FAIL last_without_valid: last=%b valid=%b", o_ot_last, o_ot_valid);
            end
            if (prev_stall) begin
                n_chk++;
                if (o_ot_valid !== 1'b1 || o_ot_fmap !== prev_fmap || o_ot_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                             o_ot_valid, o_ot_fmap, o_ot_last, prev_fmap, prev_last);
                end
            end
            n_chk++;
            if (o_ot_valid === 1'b1 && expq.size() == 0) begin
                n_fail++; $display("FAIL spurious_valid: got valid=1 d=%0d want no output", o_ot_fmap);
            end
            hs  = (o_ot_valid === 1'b1) && (i_ot_ready === 1'b1);
            rel = 0;
            if (hs && expq.size() > 0) begin
                e = expq.pop_front();
                n_out++;
                n_chk++;
                if (o_ot_fmap !== e.d || o_ot_last !== e.last) begin
                    n_fail++;
                    $display("FAIL out_data #%0d: got d=%0d l=%b want d=%0d l=%b",
                             n_out, o_ot_fmap, o_ot_last, e.d, e.last);
                end
                if (e.last) begin held--; rel = 1; end
            end
            done_pend = 0;
            if (i_in_valid === 1'b1) begin
                // A freed bank takes the write on the same cycle it is released.
                if (held < 2 || rel) begin
                    cur.push_back(i_in_fmap);
                    if (cur.size() == FRAME) begin
                        for (int k = 0; k < FRAME; k++) begin
                            e.d = cur[rd_index(k)];
                            e.last = (k == FRAME - 1);
                            expq.push_back(e);
                        end
                        cur.delete();
                        held++;
                        done_pend = 1;
                    end
                end else begin
                    exp_ov = 1;
                end
            end
            prev_stall = (o_ot_valid === 1'b1) && (i_ot_ready !== 1'b1);
            prev_fmap  = o_ot_fmap;
            prev_last  = o_ot_last;
        end
    end

    // Downstream ready generator
    initial begin
        stall_cnt = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: i_ot_ready = 1'b1;
                1: i_ot_ready = 1'b0;
                2: begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                        i_ot_ready = 1'b0;
                    end else begin
                        int r;
                        r = $urandom_range(0, 9);
                        if (r == 0) begin
                            stall_cnt = 10;
                            i_ot_ready = 1'b0;
                        end else begin
                            i_ot_ready = (r > 3);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; i_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic feed_frame(input int base, input int gap, input bit rnd);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1;
            i_in_fmap  = rnd ? DW'($urandom) : DW'(base + k);
            repeat (gap) begin
                @(posedge clk); #1;
                i_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int c;
        c = 0;
        while ((expq.size() != 0 || o_ot_valid !== 1'b0) && c < 5000) begin
            @(negedge clk); #1;
            c++;
        end
        n_chk++;
        if (c >= 5000) begin
            n_fail++;
            $display("FAIL %s drain_timeout: got %0d points pending want 0", nm, expq.size());
        end
    endtask

    task automatic test_reset();
        rdy_mode = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        n_chk++; if (o_ot_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_ot_valid); end
        n_chk++; if (o_ot_fmap !== '0)      begin n_fail++; $display("FAIL reset_fmap: got %0d want 0", o_ot_fmap); end
        n_chk++; if (o_ot_last !== 1'b0)    begin n_fail++; $display("FAIL reset_last: got %b want 0", o_ot_last); end
        n_chk++; if (o_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_frame_done); end
        n_chk++; if (o_overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
    endtask

    task automatic test_single_frame();
        do_reset();
        rdy_mode = 0;
        feed_frame(0, 3, 1'b0);
        wait_drain("single");
        n_chk++; if (n_out !== FRAME) begin n_fail++; $display("FAIL single_count: got %0d want %0d", n_out, FRAME); end
        n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", o_overflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        rdy_mode = 2;
        feed_frame(0, 0, 1'b1);
        feed_frame(0, 0, 1'b1);
        wait_drain("backpressure");
        rdy_mode = 0;
        n_chk++; if (n_out !== 2 * FRAME) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", n_out, 2 * FRAME); end
    endtask

    task automatic test_pingpong();
        do_reset();
        rdy_mode = 1;
        feed_frame(1000, 0, 1'b0);
        feed_frame(2000, 0, 1'b0);
        rdy_mode = 0;
        wait_drain("pingpong");
        n_chk++; if (n_out !== 2 * FRAME) begin n_fail++; $display("FAIL pp_count: got %0d want %0d", n_out, 2 * FRAME); end
        n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b want 0", o_overflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        rdy_mode = 1;
        feed_frame(1000, 0, 1'b0);
        feed_frame(2000, 0, 1'b0);
        feed_frame(3000, 0, 1'b0);
        rdy_mode = 0;
        wait_drain("overflow");
        n_chk++; if (n_out !== 2 * FRAME) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", n_out, 2 * FRAME); end
        n_chk++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
    endtask

    task automatic test_same_cycle_release();
        bit armed, hit;
        do_reset();
        rdy_mode = 1;
        feed_frame(1000, 0, 1'b0);
        feed_frame(2000, 0, 1'b0);
        rdy_mode = 3;
        armed = 0; hit = 0;
        // Drain frame 1 but hold its last point until frame 3's first write lines up.
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge clk); #1;
            if (armed) begin
                i_ot_ready = 1'b1;
                i_in_valid = 1'b1;
                i_in_fmap  = DW'(3000);
                hit = 1;
            end else if (o_ot_valid === 1'b1 && o_ot_last === 1'b1) begin
                i_ot_ready = 1'b0;
                armed = 1;
            end else begin
                i_ot_ready = 1'b1;
            end
        end
        n_chk++; if (!hit) begin n_fail++; $display("FAIL samecyc_align: got no last want last handshake"); end
        rdy_mode = 0;
        for (int k = 1; k < FRAME; k++) begin
            @(posedge clk); #1;
            i_in_valid = 1'b1;
            i_in_fmap  = DW'(3000 + k);
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        wait_drain("samecycle");
        n_chk++; if (n_out !== 3 * FRAME) begin n_fail++; $display("FAIL samecyc_count: got %0d want %0d", n_out, 3 * FRAME); end
        n_chk++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL samecyc_ovf: got %b want 0", o_overflow); end
    endtask

    task automatic test_reset_mid_replay();
        int c;
        do_reset();
        rdy_mode = 0;
        feed_frame(0, 0, 1'b1);
        c = 0;
        while (n_out < 70 && c < 2000) begin
            @(negedge clk); #1;
            c++;
        end
        n_chk++; if (n_out < 70) begin n_fail++; $display("FAIL midrst_reach: got %0d outputs want 70", n_out); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        n_chk++;
        if (o_ot_valid !== 1'b0 || o_ot_fmap !== '0 || o_ot_last !== 1'b0 ||
            o_frame_done !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got v=%b d=%0d l=%b fd=%b ov=%b want all 0",
                     o_ot_valid, o_ot_fmap, o_ot_last, o_frame_done, o_overflow);
        end
        repeat (10) @(negedge clk);
        feed_frame(0, 1, 1'b0);
        wait_drain("midreset");
        n_chk++; if (n_out !== FRAME) begin n_fail++; $display("FAIL midrst_count: got %0d want %0d", n_out, FRAME); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; rdy_mode = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_pingpong();
        test_overflow();
        test_same_cycle_release();
        test_reset_mid_replay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
